// File: rtl/dotp_pkg.sv
// Shared types and width helpers for the dot-product sequencer.
package dotp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    // Width that holds 2**addr_width full-width products without wrapping.
    function automatic int acc_width(input int data_width, input int addr_width);
        return 2 * data_width + addr_width;
    endfunction

endpackage

// File: rtl/dotp_mac.sv
// Multiply-accumulate register; acc_next exposes the value the next enabled edge will load.
module dotp_mac
    import dotp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = acc_width(8, 4)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic [ACC_WIDTH-1:0]  acc_next
);

    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    acc_d;
    logic [ACC_WIDTH-1:0]    acc_q;

    assign prod     = a * b;
    assign acc_next = acc_q + ACC_WIDTH'(prod);
    assign acc      = acc_q;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/dotp_seq_ctrl.sv
// Dot-product sequencer: streams reads from memories A and B, accumulates products, reports result.
module dotp_seq_ctrl
    import dotp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  result
);

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [ADDR_WIDTH-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  done_q, done_d;
    logic [ACC_WIDTH-1:0]  result_q, result_d;
    logic                  mac_clr;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_next;

    dotp_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (mac_clr),
        .en      (rd_vld_q),
        .a       (rd_data_a),
        .b       (rd_data_b),
        .acc     (acc),
        .acc_next(acc_next)
    );

    // The first read is issued on the accepting edge, so count_q holds the reads still to go.
    always_comb begin
        state_d     = state_q;
        rd_en_d     = 1'b0;
        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        count_d     = count_q;
        done_d      = 1'b0;
        result_d    = result_q;
        mac_clr     = 1'b0;
        rd_vld_d    = rd_en_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mac_clr = 1'b1;
                    if (len == '0) begin
                        result_d = '0;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        rd_en_d     = 1'b1;
                        rd_addr_a_d = base_a;
                        rd_addr_b_d = base_b;
                        count_d     = len - CNT_ONE;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (count_q != '0) begin
                    rd_en_d     = 1'b1;
                    rd_addr_a_d = rd_addr_a_q + ADDR_ONE;
                    rd_addr_b_d = rd_addr_b_q + ADDR_ONE;
                    count_d     = count_q - CNT_ONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                result_d = acc_next;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            count_q     <= '0;
            rd_vld_q    <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            count_q     <= count_d;
            rd_vld_q    <= rd_vld_d;
            done_q      <= done_d;
            result_q    <= result_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign done      = done_q;
    assign result    = result_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dotp_seq_ctrl.sv
// Randomized self-checking bench for dotp_seq_ctrl with behavioural memories and a sum-of-products model.
module tb_dotp_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  base_a;
    logic [3:0]  base_b;
    logic [4:0]  len;
    logic        rd_en;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [7:0]  rd_data_a;
    logic [7:0]  rd_data_b;
    logic        busy;
    logic        done;
    logic [19:0] result;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];

    int total = 0;
    int bad   = 0;

    int         rden_cnt;
    int         done_cnt;
    int         done_cycle;
    logic       busy_after;
    bit         held_ok;
    logic [3:0] q_addr_a [$];
    logic [3:0] q_addr_b [$];

    dotp_seq_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_a   (base_a),
        .base_b   (base_b),
        .len      (len),
        .rd_en    (rd_en),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory models with one cycle of latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr_a];
            rd_data_b <= mem_b[rd_addr_b];
        end
    end

    function automatic int ref_dot(input int ba, input int bb, input int ln);
        int s = 0;
        for (int i = 0; i < ln; i++) begin
            s += int'(mem_a[(ba + i) % 16]) * int'(mem_b[(bb + i) % 16]);
        end
        return s % (1 << 20);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'($urandom_range(1, 255));
            mem_b[i] = 8'($urandom_range(1, 255));
        end
    endtask

    // Called just after a falling edge; cycle c is the cycle following rising edge E(c-1).
    task automatic do_run(input logic [3:0] ba, input logic [3:0] bb, input logic [4:0] ln, input bit hold);
        logic [19:0] old_result;
        old_result = result;
        rden_cnt   = 0;
        done_cnt   = 0;
        done_cycle = -1;
        busy_after = 1'b1;
        held_ok    = 1'b1;
        q_addr_a.delete();
        q_addr_b.delete();
        base_a = ba;
        base_b = bb;
        len    = ln;
        start  = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (hold && c == 1) begin
                base_a = ~ba;
                base_b = ~bb;
                len    = 5'd3;
            end
            if (rd_en) begin
                rden_cnt++;
                q_addr_a.push_back(rd_addr_a);
                q_addr_b.push_back(rd_addr_b);
            end
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
                start = 1'b0;
            end else if (done_cycle < 0 && result !== old_result) begin
                held_ok = 1'b0;
            end
            if (done_cycle > 0 && c == done_cycle + 1) begin
                busy_after = busy;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        base_a = '0;
        base_b = '0;
        len    = '0;
        repeat (3) @(negedge clk);
        total++; if (rd_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_en: got %0b expected 0", rd_en); end
        total++; if (rd_addr_a !== 4'd0) begin bad++; $display("[TB] FAIL reset_addr_a: got %0d expected 0", rd_addr_a); end
        total++; if (rd_addr_b !== 4'd0) begin bad++; $display("[TB] FAIL reset_addr_b: got %0d expected 0", rd_addr_b); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        total++; if (result !== 20'd0) begin bad++; $display("[TB] FAIL reset_result: got %0d expected 0", result); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = 8'(i + 5);
        end
        do_run(4'd0, 4'd0, 5'd4, 1'b0);
        total++; if (rden_cnt != 4) begin bad++; $display("[TB] FAIL basic_rden_count: got %0d expected 4", rden_cnt); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= q_addr_a.size() || q_addr_a[i] !== 4'(i)) begin
                bad++;
                $display("[TB] FAIL basic_addr_a[%0d]: got %0d expected %0d", i, (i < q_addr_a.size()) ? q_addr_a[i] : 4'hx, i);
            end
        end
        total++; if (done_cycle != 6) begin bad++; $display("[TB] FAIL basic_done_cycle: got %0d expected 6", done_cycle); end
        total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt); end
        total++; if (result !== 20'd70) begin bad++; $display("[TB] FAIL basic_result: got %0d expected 70", result); end
        total++; if (busy_after !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_after_done: got %0b expected 0", busy_after); end
    endtask

    task automatic test_len_zero();
        do_run(4'd3, 4'd7, 5'd0, 1'b0);
        total++; if (rden_cnt != 0) begin bad++; $display("[TB] FAIL len0_rden_count: got %0d expected 0", rden_cnt); end
        total++; if (done_cycle != 1) begin bad++; $display("[TB] FAIL len0_done_cycle: got %0d expected 1", done_cycle); end
        total++; if (result !== 20'd0) begin bad++; $display("[TB] FAIL len0_result: got %0d expected 0", result); end
    endtask

    task automatic test_wrap();
        int exp;
        fill_random();
        exp = ref_dot(14, 2, 4);
        do_run(4'd14, 4'd2, 5'd4, 1'b0);
        total++; if (q_addr_a.size() != 4) begin bad++; $display("[TB] FAIL wrap_issue_count: got %0d expected 4", q_addr_a.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ea;
            logic [3:0] eb;
            ea = 4'((14 + i) % 16);
            eb = 4'(2 + i);
            total++;
            if (i >= q_addr_a.size() || q_addr_a[i] !== ea || q_addr_b[i] !== eb) begin
                bad++;
                $display("[TB] FAIL wrap_addr[%0d]: got a=%0d b=%0d expected a=%0d b=%0d", i,
                         (i < q_addr_a.size()) ? q_addr_a[i] : 4'hx, (i < q_addr_b.size()) ? q_addr_b[i] : 4'hx, ea, eb);
            end
        end
        total++; if (result !== 20'(exp)) begin bad++; $display("[TB] FAIL wrap_result: got %0d expected %0d", result, exp); end
    endtask

    task automatic test_full_max();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'd255;
            mem_b[i] = 8'd255;
        end
        do_run(4'd5, 4'd9, 5'd16, 1'b0);
        total++; if (rden_cnt != 16) begin bad++; $display("[TB] FAIL max_rden_count: got %0d expected 16", rden_cnt); end
        total++; if (done_cycle != 18) begin bad++; $display("[TB] FAIL max_done_cycle: got %0d expected 18", done_cycle); end
        total++; if (result !== 20'd1040400) begin bad++; $display("[TB] FAIL max_result: got %0d expected 1040400", result); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int ba;
            int bb;
            int ln;
            int exp;
            fill_random();
            ba  = $urandom_range(0, 15);
            bb  = $urandom_range(0, 15);
            ln  = $urandom_range(1, 16);
            exp = ref_dot(ba, bb, ln);
            do_run(4'(ba), 4'(bb), 5'(ln), 1'b0);
            total++; if (rden_cnt != ln) begin bad++; $display("[TB] FAIL rand%0d_rden_count: got %0d expected %0d", k, rden_cnt, ln); end
            total++; if (done_cycle != ln + 2) begin bad++; $display("[TB] FAIL rand%0d_done_cycle: got %0d expected %0d", k, done_cycle, ln + 2); end
            total++; if (result !== 20'(exp)) begin bad++; $display("[TB] FAIL rand%0d_result: got %0d expected %0d", k, result, exp); end
            total++;
            if (q_addr_b.size() == 0 || q_addr_b[q_addr_b.size() - 1] !== 4'((bb + ln - 1) % 16)) begin
                bad++;
                $display("[TB] FAIL rand%0d_last_addr_b: got %0d expected %0d", k,
                         (q_addr_b.size() > 0) ? q_addr_b[q_addr_b.size() - 1] : 4'hx, (bb + ln - 1) % 16);
            end
        end
    endtask

    task automatic test_start_held();
        int exp;
        int extra;
        fill_random();
        exp = ref_dot(6, 11, 7);
        do_run(4'd6, 4'd11, 5'd7, 1'b1);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rd_en || done || busy) extra++;
        end
        total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL held_done_count: got %0d expected 1", done_cnt); end
        total++; if (rden_cnt != 7) begin bad++; $display("[TB] FAIL held_rden_count: got %0d expected 7", rden_cnt); end
        total++; if (result !== 20'(exp)) begin bad++; $display("[TB] FAIL held_result: got %0d expected %0d", result, exp); end
        total++; if (extra != 0) begin bad++; $display("[TB] FAIL held_extra_activity: got %0d expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        int exp1;
        int exp2;
        fill_random();
        exp1 = ref_dot(1, 4, 5);
        exp2 = ref_dot(9, 12, 10);
        do_run(4'd1, 4'd4, 5'd5, 1'b0);
        total++; if (result !== 20'(exp1)) begin bad++; $display("[TB] FAIL b2b_first_result: got %0d expected %0d", result, exp1); end
        do_run(4'd9, 4'd12, 5'd10, 1'b0);
        total++; if (done_cycle != 12) begin bad++; $display("[TB] FAIL b2b_second_done_cycle: got %0d expected 12", done_cycle); end
        total++; if (!held_ok) begin bad++; $display("[TB] FAIL b2b_result_held: got changed expected %0d until done", exp1); end
        total++; if (result !== 20'(exp2)) begin bad++; $display("[TB] FAIL b2b_second_result: got %0d expected %0d", result, exp2); end
    endtask

    task automatic test_reset_mid();
        int reads;
        int dones;
        int exp;
        fill_random();
        reads  = 0;
        base_a = 4'd2;
        base_b = 4'd8;
        len    = 5'd8;
        start  = 1'b1;
        for (int c = 0; c < 20 && reads < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (rd_en) reads++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (rd_en !== 1'b0) begin bad++; $display("[TB] FAIL midrst_rd_en: got %0b expected 0", rd_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %0b expected 0", busy); end
        total++; if (result !== 20'd0) begin bad++; $display("[TB] FAIL midrst_result: got %0d expected 0", result); end
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        total++; if (dones != 0) begin bad++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", dones); end
        exp = ref_dot(2, 8, 8);
        do_run(4'd2, 4'd8, 5'd8, 1'b0);
        total++; if (result !== 20'(exp)) begin bad++; $display("[TB] FAIL midrst_fresh_result: got %0d expected %0d", result, exp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_full_max();
        test_random();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
